// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers 8-bit duty samples from a PWM stream by timing high time and period of each frame.
// Optional feature macro PWM_DEC_AVG_EN: report the truncated mean of the last four frame samples.
module pwm_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 512
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        pwm_in,
    output logic [7:0]  sample,
    output logic [15:0] period,
    output logic        sample_valid,
    output logic        locked
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat8(input logic [15:0] v);
        return (v > 16'd255) ? 8'd255 : v[7:0];
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_prev_q, lvl_prev_d;
    state_t                 state_q, state_d;
    logic [15:0]            hcnt_q, hcnt_d;
    logic [15:0]            pcnt_q, pcnt_d;
    logic [7:0]             sample_q, sample_d;
    logic [15:0]            period_q, period_d;
    logic                   valid_q, valid_d;
    logic [1:0]             run_q, run_d;
    logic                   locked_q, locked_d;

    logic                   lvl;
    logic                   rise;
    logic [15:0]            pcnt_inc;
    logic                   timeout;
    logic                   frame_done;
    logic [7:0]             frame_raw;
    logic                   tmo_emit;
    logic [7:0]             tmo_val;

`ifdef PWM_DEC_AVG_EN
    logic [7:0]             hist_q [3];
    logic [7:0]             hist_d [3];
    logic [1:0]             hcount_q, hcount_d;
    logic [9:0]             avg_sum;
`endif

    assign lvl      = sync_q[SYNC_STAGES-1];
    assign rise     = lvl & ~lvl_prev_q;
    assign pcnt_inc = sat_inc(pcnt_q);
    // Timeout fires in the cycle whose count would reach TIMEOUT; a coincident rise takes precedence.
    assign timeout  = (pcnt_inc >= TIMEOUT_V);

    // Frame-tracking state machine: next state, counters, and frame/timeout events.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], pwm_in};
        lvl_prev_d = lvl;
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        pcnt_d     = pcnt_q;
        frame_done = 1'b0;
        frame_raw  = 8'd0;
        tmo_emit   = 1'b0;
        tmo_val    = 8'd0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    hcnt_d  = 16'd1;
                    pcnt_d  = 16'd1;
                    state_d = HIGH;
                end else if (timeout) begin
                    tmo_emit = 1'b1;
                    tmo_val  = lvl ? 8'd255 : 8'd0;
                    hcnt_d   = 16'd0;
                    pcnt_d   = 16'd0;
                end else begin
                    pcnt_d = pcnt_inc;
                end
            end
            HIGH: begin
                if (timeout) begin
                    tmo_emit = 1'b1;
                    tmo_val  = 8'd255;
                    hcnt_d   = 16'd0;
                    pcnt_d   = 16'd0;
                    state_d  = lvl ? HIGH : LOW;
                end else if (lvl) begin
                    hcnt_d = sat_inc(hcnt_q);
                    pcnt_d = pcnt_inc;
                end else begin
                    pcnt_d  = pcnt_inc;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    frame_done = 1'b1;
                    frame_raw  = sat8(hcnt_q);
                    hcnt_d     = 16'd1;
                    pcnt_d     = 16'd1;
                    state_d    = HIGH;
                end else if (timeout) begin
                    tmo_emit = 1'b1;
                    tmo_val  = 8'd0;
                    hcnt_d   = 16'd0;
                    pcnt_d   = 16'd0;
                    state_d  = IDLE;
                end else begin
                    pcnt_d = pcnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = 16'd0;
                pcnt_d  = 16'd0;
            end
        endcase
    end

    // Output update: timeout samples go straight out, completed frames feed the lock counter.
    always_comb begin
        sample_d = sample_q;
        period_d = period_q;
        valid_d  = 1'b0;
        run_d    = run_q;
        locked_d = locked_q;
`ifdef PWM_DEC_AVG_EN
        hist_d   = hist_q;
        hcount_d = hcount_q;
        avg_sum  = {2'd0, frame_raw} + {2'd0, hist_q[0]} + {2'd0, hist_q[1]} + {2'd0, hist_q[2]};
`endif
        if (tmo_emit) begin
            sample_d = tmo_val;
            period_d = TIMEOUT_V;
            valid_d  = 1'b1;
            run_d    = 2'd0;
            locked_d = 1'b0;
`ifdef PWM_DEC_AVG_EN
            hcount_d  = 2'd0;
            hist_d[0] = 8'd0;
            hist_d[1] = 8'd0;
            hist_d[2] = 8'd0;
`endif
        end else if (frame_done) begin
            run_d    = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
            locked_d = (run_d >= 2'd2);
`ifdef PWM_DEC_AVG_EN
            hist_d[0] = frame_raw;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
            // Three older frames plus this one make the four-sample window.
            if (hcount_q == 2'd3) begin
                sample_d = 8'(avg_sum >> 2);
                period_d = pcnt_q;
                valid_d  = 1'b1;
            end else begin
                hcount_d = hcount_q + 2'd1;
            end
`else
            sample_d = frame_raw;
            period_d = pcnt_q;
            valid_d  = 1'b1;
`endif
        end else begin
            valid_d = 1'b0;
        end
    end

    // All state, counters and outputs register here; n_rst is sampled on the clock.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q     <= {SYNC_STAGES{1'b0}};
            lvl_prev_q <= 1'b0;
            state_q    <= IDLE;
            hcnt_q     <= 16'd0;
            pcnt_q     <= 16'd0;
            sample_q   <= 8'd0;
            period_q   <= 16'd0;
            valid_q    <= 1'b0;
            run_q      <= 2'd0;
            locked_q   <= 1'b0;
`ifdef PWM_DEC_AVG_EN
            hist_q[0]  <= 8'd0;
            hist_q[1]  <= 8'd0;
            hist_q[2]  <= 8'd0;
            hcount_q   <= 2'd0;
`endif
        end else begin
            sync_q     <= sync_d;
            lvl_prev_q <= lvl_prev_d;
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            pcnt_q     <= pcnt_d;
            sample_q   <= sample_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
`ifdef PWM_DEC_AVG_EN
            hist_q     <= hist_d;
            hcount_q   <= hcount_d;
`endif
        end
    end

    assign sample       = sample_q;
    assign period       = period_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed PWM frames checked every cycle against a timestamp-based frame model,
// plus hand-computed expectations on the captured sample_valid events.
module tb_pwm_decoder;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 512;
`ifdef PWM_DEC_AVG_EN
    localparam int AVG_SKIP = 3;
    localparam int MIX_LAST = 25;
`else
    localparam int AVG_SKIP = 0;
    localparam int MIX_LAST = 41;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic        pwm_in;
    logic [7:0]  sample;
    logic [15:0] period;
    logic        sample_valid;
    logic        locked;

    pwm_decoder #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .pwm_in       (pwm_in),
        .sample       (sample),
        .period       (period),
        .sample_valid (sample_valid),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rise = 0;
    int ev_cyc[$];
    int ev_sample[$];
    int ev_period[$];
    int ev_locked[$];

    // Model: frames are intervals between synchronised rises; values come from timestamps and high counts.
    bit live = 1'b0;
    bit sh [SYNC_STAGES+1];
    int anchor, ones, run, v;
    bit started, fell, l, lp, rise;
    int e_sample, e_period;
    bit e_valid, e_locked;
    int hq[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!n_rst) begin
                live = 1'b1;
                for (int i = 0; i <= SYNC_STAGES; i++) sh[i] = 1'b0;
                anchor = cyc + 1;
                ones = 0; run = 0; started = 1'b0; fell = 1'b0;
                e_sample = 0; e_period = 0; e_valid = 1'b0; e_locked = 1'b0;
                hq.delete();
            end else begin
                l = sh[SYNC_STAGES-1];
                lp = sh[SYNC_STAGES];
                rise = l && !lp;
                e_valid = 1'b0;
                if (rise && started && fell) begin
                    run = (run < 3) ? run + 1 : 3;
                    e_locked = (run >= 2);
                    v = (ones > 255) ? 255 : ones;
`ifdef PWM_DEC_AVG_EN
                    hq.push_back(v);
                    if (hq.size() > 4) void'(hq.pop_front());
                    if (hq.size() == 4) begin
                        e_valid = 1'b1;
                        e_sample = (hq[0] + hq[1] + hq[2] + hq[3]) / 4;
                        e_period = cyc - anchor;
                    end
`else
                    e_valid = 1'b1;
                    e_sample = v;
                    e_period = cyc - anchor;
`endif
                    anchor = cyc; ones = 1; fell = 1'b0;
                end else if (rise) begin
                    started = 1'b1; fell = 1'b0; anchor = cyc; ones = 1;
                end else if (cyc - anchor + 1 >= TIMEOUT) begin
                    e_valid = 1'b1; e_period = TIMEOUT; run = 0; e_locked = 1'b0;
                    hq.delete();
                    if ((started && !fell) || (!started && l)) begin
                        e_sample = 255;
                        if (started) fell = !l;
                    end else begin
                        e_sample = 0; started = 1'b0; fell = 1'b0;
                    end
                    anchor = cyc + 1; ones = 0;
                end else if (started && !fell) begin
                    if (l) ones++;
                    else fell = 1'b1;
                end
                for (int i = SYNC_STAGES; i > 0; i--) sh[i] = sh[i-1];
                sh[0] = pwm_in;
            end
        end
    end

    // Per-cycle compare against the model, and capture of every valid pulse for directed checks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (live) begin
                check("valid", sample_valid, e_valid);
                check("sample", sample, e_sample);
                check("period", period, e_period);
                check("locked", locked, e_locked);
                if (sample_valid) begin
                    ev_cyc.push_back(cyc);
                    ev_sample.push_back(sample);
                    ev_period.push_back(period);
                    ev_locked.push_back(locked);
                end
            end
        end
    end

    task automatic drive(input logic val, input int n);
        for (int i = 0; i < n; i++) begin
            if (val && !pwm_in) last_rise = cyc;
            pwm_in = val;
            @(negedge clk);
        end
    endtask

    task automatic frame(input int h, input int p);
        drive(1'b1, h);
        drive(1'b0, p - h);
    endtask

    task automatic clear_ev();
        ev_cyc.delete(); ev_sample.delete(); ev_period.delete(); ev_locked.delete();
    endtask

    task automatic reset_dut(input logic val);
        n_rst = 1'b0;
        drive(val, 3);
        n_rst = 1'b1;
        clear_ev();
    endtask

    task automatic check_all(input string name, input int s, input int p);
        for (int i = 0; i < ev_cyc.size(); i++) begin
            check({name, "_sample"}, ev_sample[i], s);
            check({name, "_period"}, ev_period[i], p);
        end
    endtask

    int rel, rb;

    initial begin
        n_rst = 1'b0;
        pwm_in = 1'b0;
        // Reset with a toggling input.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pwm_in = ~pwm_in;
        end
        check("rst_sample", sample, 0);
        check("rst_period", period, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_locked", locked, 0);

        // Steady 100/256 frames.
        pwm_in = 1'b0;
        n_rst = 1'b1;
        clear_ev();
        drive(1'b0, 20);
        repeat (5) frame(100, 256);
        drive(1'b1, 10);
        check("steady_count", ev_cyc.size(), 5 - AVG_SKIP);
        check_all("steady", 100, 256);
        check("steady_latency", ev_cyc[$] - last_rise, 3);
        check("steady_spacing", ev_cyc[1] - ev_cyc[0], 256);
        check("steady_lock_first", ev_locked[0], (AVG_SKIP > 0) ? 1 : 0);
        check("steady_locked", locked, 1);

        // Constant low: 0 every TIMEOUT cycles.
        reset_dut(1'b0);
        rel = cyc;
        drive(1'b0, 2000);
        check("low_count", ev_cyc.size(), 3);
        check_all("low", 0, 512);
        check("low_first", ev_cyc[0] - rel, 512);
        check("low_spacing", ev_cyc[2] - ev_cyc[1], 512);
        check("low_locked", locked, 0);

        // Constant high: 255 every TIMEOUT cycles.
        reset_dut(1'b0);
        rel = cyc;
        drive(1'b1, 2000);
        check("high_count", ev_cyc.size(), 3);
        check_all("high", 255, 512);
        check("high_first", ev_cyc[0] - rel, 514);
        check("high_spacing", ev_cyc[1] - ev_cyc[0], 512);
        check("high_locked", locked, 0);

        // High time beyond 255 saturates the sample.
        reset_dut(1'b0);
        drive(1'b0, 10);
        repeat (4) frame(300, 400);
        drive(1'b1, 5);
        check("sat_count", ev_cyc.size(), 4 - AVG_SKIP);
        check_all("sat", 255, 400);

        // Reset in the middle of a high phase discards the partial frame.
        reset_dut(1'b0);
        drive(1'b0, 10);
        repeat (3) frame(64, 256);
        drive(1'b1, 30);
        check("pre_reset_locked", locked, 1);
        n_rst = 1'b0;
        drive(1'b1, 34);
        drive(1'b0, 40);
        check("mid_reset_locked", locked, 0);
        check("mid_reset_sample", sample, 0);
        n_rst = 1'b1;
        clear_ev();
        drive(1'b0, 152);
        frame(64, 256);
        drive(1'b1, 64);
        rb = last_rise;
        drive(1'b0, 192);
        repeat (2) frame(64, 256);
        drive(1'b1, 5);
        check("resume_count", ev_cyc.size(), 4 - AVG_SKIP);
        check("resume_sample", ev_sample[0], 64);
        check("resume_period", ev_period[0], 256);
        check("resume_first", ev_cyc[0] - rb, 3 + 256 * AVG_SKIP);

        // Single-cycle high pulses are valid frames.
        reset_dut(1'b0);
        drive(1'b0, 10);
        repeat (4) frame(1, 50);
        drive(1'b1, 1);
        drive(1'b0, 10);
        check("glitch_count", ev_cyc.size(), 4 - AVG_SKIP);
        check_all("glitch", 1, 50);

        // Mixed duty: 10, 20, 30, 41.
        reset_dut(1'b0);
        drive(1'b0, 10);
        frame(10, 100);
        frame(20, 100);
        frame(30, 100);
        frame(41, 100);
        drive(1'b1, 5);
        check("mix_count", ev_cyc.size(), 4 - AVG_SKIP);
        check("mix_last", ev_sample[$], MIX_LAST);
        check("mix_period", ev_period[$], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
